// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX/MEM/WB hazard-control signal bundle.
//   master : pipeline side; drives ID/EX/MEM/WB fields and consumes the controls
//   slave  : hazard controller; consumes pipeline fields and drives
//            Forward1A/B, stall, ID_EX_bubble, mdu_start/busy, hilo_valid, stall_cnt
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_use_rs;
    logic             ID_use_rt;
    logic             ID_is_mdu;
    logic             ID_reads_hilo;
    logic [4:0]       EX_rd;
    logic             EX_regwrite;
    logic [4:0]       MEM_rd;
    logic             MEM_regwrite;
    logic             MEM_memread;
    logic [4:0]       WB_rd;
    logic             WB_regwrite;

    logic [1:0]       Forward1A;
    logic [1:0]       Forward1B;
    logic             stall;
    logic             ID_EX_bubble;
    logic             mdu_start;
    logic             mdu_busy;
    logic             hilo_valid;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_is_mdu, ID_reads_hilo,
        output EX_rd, EX_regwrite, MEM_rd, MEM_regwrite, MEM_memread,
        output WB_rd, WB_regwrite,
        input  Forward1A, Forward1B, stall, ID_EX_bubble,
        input  mdu_start, mdu_busy, hilo_valid, stall_cnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_is_mdu, ID_reads_hilo,
        input  EX_rd, EX_regwrite, MEM_rd, MEM_regwrite, MEM_memread,
        input  WB_rd, WB_regwrite,
        output Forward1A, Forward1B, stall, ID_EX_bubble,
        output mdu_start, mdu_busy, hilo_valid, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage forwarding selects, load-use / producer-in-EX stall,
// multiply/divide busy interlock with its sequencing FSM, and a saturating
// stall-cycle counter.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : hazard_ctrl_if.slave (pipeline fields in, controls out)
//   Forward1A/B, stall, ID_EX_bubble, mdu_start are combinational;
//   mdu_busy, hilo_valid are decoded from the FSM state; stall_cnt is a flop.
module hazard_ctrl #(
    parameter int unsigned MDU_CYCLES = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    hazard_ctrl_if.slave    bus
);

    localparam int unsigned MCNT_W = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [MCNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [1:0]          fwd_a_c, fwd_b_c;
    logic                data_hazard_c;
    logic                mdu_hazard_c;
    logic                stall_c;
    logic                mdu_start_c;

    // Operand select for one source: EX/MEM ALU result beats MEM/WB writeback.
    // Loads in MEM are excluded since their data is not available yet.
    function automatic logic [1:0] fwd_sel(
        input logic       use_x,
        input logic [4:0] src,
        input logic       mem_rw,
        input logic       mem_rd_en,
        input logic [4:0] mem_rd,
        input logic       wb_rw,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_x) begin
            if (mem_rw && !mem_rd_en && (mem_rd != 5'd0) && (mem_rd == src)) begin
                sel = 2'b10;
            end else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // Source depends on a result not yet in a forwardable pipeline register.
    function automatic logic src_hazard(
        input logic       use_x,
        input logic [4:0] src,
        input logic       ex_rw,
        input logic [4:0] ex_rd,
        input logic       mem_rw,
        input logic       mem_rd_en,
        input logic [4:0] mem_rd
    );
        return use_x && (src != 5'd0) &&
               ((ex_rw && (ex_rd == src)) ||
                (mem_rw && mem_rd_en && (mem_rd == src)));
    endfunction

    // Forwarding and hazard detection; everything forced quiet during reset.
    always_comb begin
        fwd_a_c       = 2'b00;
        fwd_b_c       = 2'b00;
        data_hazard_c = 1'b0;
        if (!rst) begin
            fwd_a_c = fwd_sel(bus.ID_use_rs, bus.ID_rs, bus.MEM_regwrite,
                              bus.MEM_memread, bus.MEM_rd, bus.WB_regwrite, bus.WB_rd);
            fwd_b_c = fwd_sel(bus.ID_use_rt, bus.ID_rt, bus.MEM_regwrite,
                              bus.MEM_memread, bus.MEM_rd, bus.WB_regwrite, bus.WB_rd);
            data_hazard_c =
                src_hazard(bus.ID_use_rs, bus.ID_rs, bus.EX_regwrite, bus.EX_rd,
                           bus.MEM_regwrite, bus.MEM_memread, bus.MEM_rd) ||
                src_hazard(bus.ID_use_rt, bus.ID_rt, bus.EX_regwrite, bus.EX_rd,
                           bus.MEM_regwrite, bus.MEM_memread, bus.MEM_rd);
        end
    end

    // HI/LO are only unsafe while BUSY; in DONE they are written this cycle.
    assign mdu_hazard_c = (state_q == BUSY) && (bus.ID_is_mdu || bus.ID_reads_hilo);
    assign stall_c      = !rst && (data_hazard_c || mdu_hazard_c);

    // MDU sequencer: next state, down-counter and start pulse.
    // Counter loads MDU_CYCLES-2 so that BUSY lasts MDU_CYCLES-1 cycles
    // (terminal count 0 is itself a BUSY cycle) and DONE lands at start+MDU_CYCLES.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mdu_start_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (!rst && bus.ID_is_mdu && !data_hazard_c) begin
                    mdu_start_c = 1'b1;
                    state_d     = BUSY;
                    cnt_d       = MCNT_W'(MDU_CYCLES - 2);
                end else begin
                    state_d     = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - MCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.Forward1A    = fwd_a_c;
    assign bus.Forward1B    = fwd_b_c;
    assign bus.stall        = stall_c;
    assign bus.ID_EX_bubble = stall_c;
    assign bus.mdu_start    = mdu_start_c;
    assign bus.mdu_busy     = (state_q == BUSY);
    assign bus.hilo_valid   = (state_q == DONE);
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_CYCLES=4, CNT_W=4).
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    hazard_ctrl_if #(.CNT_W(4)) bus ();

    hazard_ctrl #(
        .MDU_CYCLES (4),
        .CNT_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.ID_rs         = 5'd0;
        bus.ID_rt         = 5'd0;
        bus.ID_use_rs     = 1'b0;
        bus.ID_use_rt     = 1'b0;
        bus.ID_is_mdu     = 1'b0;
        bus.ID_reads_hilo = 1'b0;
        bus.EX_rd         = 5'd0;
        bus.EX_regwrite   = 1'b0;
        bus.MEM_rd        = 5'd0;
        bus.MEM_regwrite  = 1'b0;
        bus.MEM_memread   = 1'b0;
        bus.WB_rd         = 5'd0;
        bus.WB_regwrite   = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clr();
        // Hazardous inputs while in reset: everything must stay quiet.
        bus.MEM_rd = 5'd5; bus.MEM_regwrite = 1'b1;
        bus.EX_rd = 5'd5;  bus.EX_regwrite = 1'b1;
        bus.ID_rs = 5'd5;  bus.ID_use_rs = 1'b1;
        bus.ID_is_mdu = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_fwd_a",     16'(bus.Forward1A), 16'h0);
        chk("rst_stall",     16'(bus.stall), 16'h0);
        chk("rst_bubble",    16'(bus.ID_EX_bubble), 16'h0);
        chk("rst_start",     16'(bus.mdu_start), 16'h0);
        chk("rst_busy",      16'(bus.mdu_busy), 16'h0);
        chk("rst_hilo",      16'(bus.hilo_valid), 16'h0);
        chk("rst_stall_cnt", 16'(bus.stall_cnt), 16'h0);
        clr();
        rst = 1'b0;

        // EX/MEM beats MEM/WB for the same register.
        step();
        bus.MEM_rd = 5'd5; bus.MEM_regwrite = 1'b1;
        bus.WB_rd = 5'd5;  bus.WB_regwrite = 1'b1;
        bus.ID_rs = 5'd5;  bus.ID_use_rs = 1'b1;
        #1;
        chk("prio_fwd_a", 16'(bus.Forward1A), 16'h2);
        chk("prio_stall", 16'(bus.stall), 16'h0);
        bus.ID_use_rs = 1'b0;
        #1;
        chk("unused_fwd_a", 16'(bus.Forward1A), 16'h0);

        // WB forward on rt; $0 never forwards.
        step();
        clr();
        bus.WB_rd = 5'd7;  bus.WB_regwrite = 1'b1;
        bus.MEM_rd = 5'd0; bus.MEM_regwrite = 1'b1;
        bus.ID_rt = 5'd7;  bus.ID_use_rt = 1'b1;
        bus.ID_rs = 5'd0;  bus.ID_use_rs = 1'b1;
        #1;
        chk("wb_fwd_b", 16'(bus.Forward1B), 16'h1);
        chk("r0_fwd_a", 16'(bus.Forward1A), 16'h0);

        // Load-use: one stall, then forward from MEM/WB.
        step();
        clr();
        bus.MEM_rd = 5'd3; bus.MEM_regwrite = 1'b1; bus.MEM_memread = 1'b1;
        bus.ID_rs = 5'd3;  bus.ID_use_rs = 1'b1;
        #1;
        chk("lu_stall",  16'(bus.stall), 16'h1);
        chk("lu_bubble", 16'(bus.ID_EX_bubble), 16'h1);
        chk("lu_fwd_a",  16'(bus.Forward1A), 16'h0);
        step();
        bus.MEM_rd = 5'd0; bus.MEM_regwrite = 1'b0; bus.MEM_memread = 1'b0;
        bus.WB_rd = 5'd3;  bus.WB_regwrite = 1'b1;
        #1;
        chk("lu2_fwd_a",    16'(bus.Forward1A), 16'h1);
        chk("lu2_stall",    16'(bus.stall), 16'h0);
        chk("lu2_stall_cnt", 16'(bus.stall_cnt), 16'h1);

        // Producer in EX on rt; ignored when rt is not read.
        step();
        clr();
        bus.EX_rd = 5'd9; bus.EX_regwrite = 1'b1;
        bus.ID_rt = 5'd9; bus.ID_use_rt = 1'b0;
        #1;
        chk("ex_unused_stall", 16'(bus.stall), 16'h0);
        bus.ID_use_rt = 1'b1;
        #1;
        chk("ex_stall", 16'(bus.stall), 16'h1);
        step();
        clr();
        #1;
        chk("ex_stall_cnt", 16'(bus.stall_cnt), 16'h2);

        // MDU op with mflo interlock.
        step();
        bus.ID_is_mdu = 1'b1;
        #1;
        chk("mdu_start_T", 16'(bus.mdu_start), 16'h1);
        chk("mdu_busy_T",  16'(bus.mdu_busy), 16'h0);
        step();
        bus.ID_is_mdu = 1'b0;
        #1;
        chk("mdu_busy_T1",  16'(bus.mdu_busy), 16'h1);
        chk("mdu_start_T1", 16'(bus.mdu_start), 16'h0);
        chk("mdu_stall_T1", 16'(bus.stall), 16'h0);
        step();
        bus.ID_reads_hilo = 1'b1;
        #1;
        chk("mflo_stall_T2", 16'(bus.stall), 16'h1);
        step();
        chk("mdu_busy_T3",   16'(bus.mdu_busy), 16'h1);
        chk("mflo_stall_T3", 16'(bus.stall), 16'h1);
        chk("mdu_hilo_T3",   16'(bus.hilo_valid), 16'h0);
        step();
        chk("mdu_hilo_T4",   16'(bus.hilo_valid), 16'h1);
        chk("mdu_busy_T4",   16'(bus.mdu_busy), 16'h0);
        chk("mflo_stall_T4", 16'(bus.stall), 16'h0);
        chk("mdu_stall_cnt", 16'(bus.stall_cnt), 16'h4);
        bus.ID_reads_hilo = 1'b0;
        step();
        chk("mdu_hilo_T5", 16'(bus.hilo_valid), 16'h0);

        // Back-to-back: new op starts from DONE straight into BUSY.
        bus.ID_is_mdu = 1'b1;
        #1;
        chk("b2b_start_S", 16'(bus.mdu_start), 16'h1);
        step();
        bus.ID_is_mdu = 1'b0;
        repeat (3) step();
        bus.ID_is_mdu = 1'b1;
        #1;
        chk("b2b_hilo_S4",  16'(bus.hilo_valid), 16'h1);
        chk("b2b_start_S4", 16'(bus.mdu_start), 16'h1);
        chk("b2b_stall_S4", 16'(bus.stall), 16'h0);
        step();
        bus.ID_is_mdu = 1'b0;
        chk("b2b_busy_S5", 16'(bus.mdu_busy), 16'h1);
        chk("b2b_hilo_S5", 16'(bus.hilo_valid), 16'h0);
        repeat (3) step();
        chk("b2b_hilo_S8", 16'(bus.hilo_valid), 16'h1);
        step();

        // Start held off by a data hazard, then reset mid-operation.
        bus.ID_is_mdu = 1'b1;
        bus.ID_rs = 5'd9; bus.ID_use_rs = 1'b1;
        bus.EX_rd = 5'd9; bus.EX_regwrite = 1'b1;
        #1;
        chk("blk_start", 16'(bus.mdu_start), 16'h0);
        chk("blk_stall", 16'(bus.stall), 16'h1);
        step();
        bus.EX_regwrite = 1'b0;
        #1;
        chk("retry_start",     16'(bus.mdu_start), 16'h1);
        chk("retry_stall_cnt", 16'(bus.stall_cnt), 16'h5);
        step();
        clr();
        step();
        chk("pre_rst_busy", 16'(bus.mdu_busy), 16'h1);
        rst = 1'b1;
        #1;
        chk("midrst_busy",      16'(bus.mdu_busy), 16'h0);
        chk("midrst_hilo",      16'(bus.hilo_valid), 16'h0);
        chk("midrst_stall_cnt", 16'(bus.stall_cnt), 16'h0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_hilo", 16'(bus.hilo_valid), 16'h0);
            chk("post_rst_busy", 16'(bus.mdu_busy), 16'h0);
        end

        // Continuous stall saturates the 4-bit counter at 15.
        bus.EX_rd = 5'd4; bus.EX_regwrite = 1'b1;
        bus.ID_rs = 5'd4; bus.ID_use_rs = 1'b1;
        repeat (10) step();
        chk("sat_cnt_10", 16'(bus.stall_cnt), 16'ha);
        repeat (10) step();
        chk("sat_cnt_20", 16'(bus.stall_cnt), 16'hf);
        clr();
        step();
        chk("sat_hold",  16'(bus.stall_cnt), 16'hf);
        chk("sat_stall", 16'(bus.stall), 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
